// File: rtl/data_mem_store_buffer.sv
// Posted-write store buffer between the core load/store path and DataMem.
// Stores queue in a DEPTH-entry FIFO and retire to DataMem on idle memory cycles.
// Loads go straight to DataMem unless a pending store to the same word exists.
// Optional feature: define STORE_BUF_COALESCE_EN to merge stores to a word already pending.
module data_mem_store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_cpu_read,
  input  logic          i_cpu_write,
  input  logic [AW-1:0] i_cpu_address,
  input  logic [DW-1:0] i_cpu_write_data,
  output logic [DW-1:0] o_cpu_read_data,
  output logic          o_stall,
  output logic          o_mem_read,
  output logic          o_mem_write,
  output logic [AW-1:0] o_mem_address,
  output logic [DW-1:0] o_mem_write_data,
  input  logic [DW-1:0] i_mem_read_data,
  output logic          o_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [AW-3:0] r_addr [DEPTH];
  logic [DW-1:0] r_data [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [PW:0]   r_count;

  logic [AW-3:0] w_cpu_word;
  logic [DEPTH-1:0] w_match;
  logic          w_hit;
  logic [PW-1:0] w_hit_idx;
  logic [DW-1:0] w_hit_data;
  logic          w_full;
  logic          w_store;
  logic          w_coal;
  logic          w_stall;
  logic          w_enq;
  logic          w_drain;

  assign w_cpu_word = i_cpu_address[AW-1:2];
  assign w_full     = (r_count == FULL_CNT);

  // Per physical slot: valid when its age (distance from head) is below count, then address compare
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      logic [PW-1:0] w_age;
      assign w_age = PW'(gi) - r_head;
      assign w_match[gi] = ({1'b0, w_age} < r_count) && (r_addr[gi] == w_cpu_word);
    end
  endgenerate

  // Walk slots oldest to youngest so the youngest matching entry wins
  always_comb begin
    w_hit      = 1'b0;
    w_hit_idx  = '0;
    w_hit_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_match[r_head + PW'(i)]) begin
        w_hit      = 1'b1;
        w_hit_idx  = r_head + PW'(i);
        w_hit_data = r_data[r_head + PW'(i)];
      end
    end
  end

`ifdef STORE_BUF_COALESCE_EN
  assign w_coal = i_cpu_write && w_hit;
`else
  assign w_coal = 1'b0;
`endif

  // Cycle classification: a full store stalls and lets the head drain so the retry can succeed
  assign w_store = i_cpu_write && !i_cpu_read;
  assign w_stall = w_store && w_full && !w_coal;
  assign w_enq   = w_store && !w_full && !w_coal;
  assign w_drain = !i_cpu_read && (r_count != '0) && (!i_cpu_write || w_stall);

  assign o_stall          = w_stall;
  assign o_empty          = (r_count == '0);
  assign o_mem_read       = i_cpu_read;
  assign o_mem_write      = w_drain;
  assign o_mem_address    = i_cpu_read ? i_cpu_address :
                            (w_drain ? {r_addr[r_head], 2'b00} : '0);
  assign o_mem_write_data = w_drain ? r_data[r_head] : '0;
  assign o_cpu_read_data  = i_cpu_read ? (w_hit ? w_hit_data : i_mem_read_data) : '0;

  // Pointer and occupancy bookkeeping; enqueue and drain are mutually exclusive
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (w_enq) begin
      r_tail  <= r_tail + 1'b1;
      r_count <= r_count + 1'b1;
    end else if (w_drain) begin
      r_head  <= r_head + 1'b1;
      r_count <= r_count - 1'b1;
    end
  end

  // Entry storage: contents are meaningless outside the valid window, so no reset
  always_ff @(posedge i_clk) begin
    if (w_enq) begin
      r_addr[r_tail] <= w_cpu_word;
      r_data[r_tail] <= i_cpu_write_data;
    end else if (w_coal) begin
      r_data[w_hit_idx] <= i_cpu_write_data;
    end
  end

endmodule
